// File: rtl/ps2_host_tx_if.sv
// Byte handshake between game control logic and the PS/2 host transmitter.
// The controller drives tx_data/tx_valid; the transmitter answers with ready and result pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the open-drain clk/data pair.
// Define PS2_TX_RETRY_EN to retry a failed byte once before reporting tx_err.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic               VGA_clk,
    input  logic               reset,
    ps2_host_tx_if.slave       bus,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    output logic               ps2_clk_oe,
    output logic               ps2_data_oe
);

    localparam int unsigned TimerMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                       INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam int unsigned FiltW    = $clog2(FILTER_LEN + 1);

    localparam logic [TimerW-1:0] InhibitLast = TimerW'(INHIBIT_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [FiltW-1:0]  FiltLast    = FiltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StWaitIdle,
        StDone,
        StErr
    } state_t;

    logic clk_meta, clk_sync, data_meta, data_sync;
    logic clk_filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic clk_flip, fe;

    state_t state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0] n_q, n_d;
    logic [9:0] frame_q, frame_d;
    logic bit_q, bit_d;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // A new clock level is accepted after FILTER_LEN consecutive samples that differ from it.
    always_comb begin
        clk_flip = (clk_sync != clk_filt_q) && (filt_cnt_q == FiltLast);
        fe       = clk_flip && clk_filt_q;
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_sync == clk_filt_q) begin
            filt_cnt_q <= '0;
        end else if (clk_flip) begin
            clk_filt_q <= clk_sync;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

`ifdef PS2_TX_RETRY_EN
    logic retried_q, retried_d;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            retried_q <= 1'b0;
        end else begin
            retried_q <= retried_d;
        end
    end
`endif

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            n_q     <= '0;
            frame_q <= '0;
            bit_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            n_q     <= n_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        n_d          = n_q;
        frame_d      = frame_q;
        bit_d        = bit_q;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        bus.tx_ready = 1'b0;
        bus.tx_done  = 1'b0;
        bus.tx_err   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retried_d    = retried_q;
`endif

        // The device timeout runs in every state that waits on the device.
        if (state_q == StReq || state_q == StData || state_q == StWaitIdle) begin
            timer_d = fe ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                bus.tx_ready = 1'b1;
                if (bus.tx_valid) begin
                    frame_d = {1'b1, ~^bus.tx_data, bus.tx_data};
                    n_d     = '0;
                    timer_d = '0;
                    state_d = StInhibit;
`ifdef PS2_TX_RETRY_EN
                    retried_d = 1'b0;
`endif
                end
            end
            StInhibit: begin
                ps2_clk_oe = 1'b1;
                if (timer_q == InhibitLast) begin
                    ps2_data_oe = 1'b1;
                    timer_d     = '0;
                    bit_d       = 1'b0;
                    state_d     = StReq;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StReq: begin
                ps2_data_oe = 1'b1;
                if (fe) begin
                    bit_d   = frame_q[0];
                    n_d     = 4'd1;
                    state_d = StData;
                end
            end
            StData: begin
                // Stop bit is 1 in the frame, so n=10 releases the line on its own.
                ps2_data_oe = ~bit_q;
                if (fe) begin
                    n_d = n_q + 1'b1;
                    if (n_q == 4'd10) begin
                        state_d = data_sync ? StErr : StWaitIdle;
                    end else begin
                        bit_d = frame_q[n_q];
                    end
                end
            end
            StWaitIdle: begin
                if (clk_sync && data_sync) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.tx_done = 1'b1;
                state_d     = StIdle;
            end
            StErr: begin
`ifdef PS2_TX_RETRY_EN
                if (!retried_q) begin
                    retried_d = 1'b1;
                    timer_d   = '0;
                    n_d       = '0;
                    state_d   = StInhibit;
                end else begin
                    bus.tx_err = 1'b1;
                    state_d    = StIdle;
                end
`else
                bus.tx_err = 1'b1;
                state_d    = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StReq || state_q == StData || state_q == StWaitIdle) &&
            !fe && timer_q == TimeoutLast) begin
            state_d = StErr;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a keyboard model answers frames and a monitor checks each
// tx_done/tx_err pulse against the queued expectation.
module tb_ps2_host_tx;

    localparam int unsigned Inhibit = 2500;
    localparam int unsigned Timeout = 3000;
    localparam int unsigned Half    = 20;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic VGA_clk = 1'b0;
    logic reset   = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_line, ps2_data_line;

    ps2_host_tx_if bus ();

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .TIMEOUT_CYCLES(Timeout),
        .FILTER_LEN    (4)
    ) dut (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .bus        (bus),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #20 VGA_clk = ~VGA_clk;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    logic [9:0] rx_bits;
    logic [9:0] rx_frame = '0;
    bit dev_ack = 1'b1;
    bit dev_silent = 1'b0;
    bit dev_busy = 1'b0;
    int dev_edges = 0;
    bit pulse_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge VGA_clk);
    endtask

    task automatic push_exp(input logic [7:0] b, input logic is_err, input logic par);
        exp_t e;
        e.is_err = is_err;
        e.data   = b;
        e.par    = par;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge of the first INHIBIT cycle.
    task automatic send(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge VGA_clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((!bus.tx_ready || exp_q.size() != 0 || dev_busy) && k < budget) begin
            @(negedge VGA_clk);
            k++;
        end
        check({name, "_completes"}, 32'(k < budget), 32'd1);
    endtask

    // Keyboard model: clocks the frame out on request, samples data on rising edges, then ACKs.
    initial begin
        forever begin
            @(negedge VGA_clk);
            if (!reset && ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) begin
                dev_busy  = 1'b1;
                dev_edges = 0;
                if (dev_silent) begin
                    while (ps2_data_oe === 1'b1) @(negedge VGA_clk);
                end else begin
                    tick(Half);
                    for (int i = 0; i < 10; i++) begin
                        dev_clk = 1'b0;
                        dev_edges++;
                        tick(Half);
                        dev_clk = 1'b1;
                        rx_bits[i] = ps2_data_line;
                        tick(Half);
                    end
                    rx_frame = rx_bits;
                    dev_data = ~dev_ack;
                    tick(Half);
                    dev_clk = 1'b0;
                    dev_edges++;
                    tick(Half);
                    dev_clk = 1'b1;
                    tick(Half);
                    dev_data = 1'b1;
                end
                dev_busy = 1'b0;
            end
        end
    end

    always @(negedge VGA_clk) begin
        exp_t e;
        if (bus.tx_done === 1'b1 || bus.tx_err === 1'b1) begin
            check("pulse_one_cycle", 32'(pulse_prev), 32'd0);
            check("done_err_exclusive", 32'(bus.tx_done & bus.tx_err), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b, required no pulse",
                         bus.tx_done, bus.tx_err);
            end else begin
                e = exp_q.pop_front();
                check("outcome", 32'({bus.tx_done, bus.tx_err}),
                      e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("rx_byte", 32'(rx_frame[7:0]), 32'(e.data));
                    check("rx_parity", 32'(rx_frame[8]), 32'(e.par));
                    check("rx_stop", 32'(rx_frame[9]), 32'd1);
                end
            end
        end
        pulse_prev = (bus.tx_done === 1'b1) || (bus.tx_err === 1'b1);
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vec_data[4];
        logic       vec_par[4];
        int k;
        int dhigh;
        logic last_d;
        vec_data = '{8'h00, 8'hF4, 8'h01, 8'h55};
        vec_par  = '{1'b1, 1'b0, 1'b0, 1'b1};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_ready", 32'(bus.tx_ready), 32'd1);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_done_err", 32'({bus.tx_done, bus.tx_err}), 32'd0);

        // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, five... six ones -> odd parity 1
        push_exp(8'hED, 1'b0, 1'b1);
        send(8'hED);
        wait_done("ed", 8000);

        // Inhibit window measured with 0xFF
        push_exp(8'hFF, 1'b0, 1'b1);
        send(8'hFF);
        k = 0;
        dhigh = 0;
        last_d = 1'b0;
        while (ps2_clk_oe === 1'b1 && k < 5000) begin
            k++;
            last_d = ps2_data_oe;
            if (ps2_data_oe === 1'b1) dhigh++;
            @(negedge VGA_clk);
        end
        check("inhibit_cycles", 32'(k), 32'(Inhibit));
        check("inhibit_start_bit_cycles", 32'(dhigh), 32'd1);
        check("inhibit_start_on_last", 32'(last_d), 32'd1);
        check("req_data_oe", 32'(ps2_data_oe), 32'd1);
        wait_done("ff", 8000);

        foreach (vec_data[i]) begin
            push_exp(vec_data[i], 1'b0, vec_par[i]);
            send(vec_data[i]);
            wait_done("vec", 8000);
        end

        // Device does not ACK
        dev_ack = 1'b0;
        push_exp(8'h12, 1'b1, 1'b0);
        send(8'h12);
        wait_done("nack", 16000);
        dev_ack = 1'b1;

        // Device never clocks: tx_err a fixed distance after REQ entry
        dev_silent = 1'b1;
        push_exp(8'h55, 1'b1, 1'b1);
        send(8'h55);
        k = 0;
        while (ps2_clk_oe === 1'b1 && k < 5000) begin
            @(negedge VGA_clk);
            k++;
        end
        k = 0;
        while (bus.tx_err !== 1'b1 && k < 3 * Timeout + Inhibit) begin
            @(negedge VGA_clk);
            k++;
        end
`ifdef PS2_TX_RETRY_EN
        check("timeout_cycles", 32'(k), 32'(2 * Timeout + Inhibit + 1));
`else
        check("timeout_cycles", 32'(k), 32'(Timeout));
`endif
        check("timeout_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        wait_done("timeout", 2000);
        dev_silent = 1'b0;

        // Reset in the middle of a frame
        send(8'hED);
        k = 0;
        while (dev_edges < 5 && k < 8000) begin
            @(negedge VGA_clk);
            k++;
        end
        tick(10);
        check("n5_drives_d4_low", 32'(ps2_data_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("abort_data_oe", 32'(ps2_data_oe), 32'd0);
        check("abort_ready", 32'(bus.tx_ready), 32'd1);
        check("abort_done_err", 32'({bus.tx_done, bus.tx_err}), 32'd0);
        wait_done("abort", 2000);

        // tx_valid with 0x00 while busy with 0xED
        push_exp(8'hED, 1'b0, 1'b1);
        send(8'hED);
        tick(100);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        wait_done("busy_ignore", 8000);
        tick(50);
        check("busy_ignore_idle", 32'(bus.tx_ready && !ps2_clk_oe), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
